// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes, execute-stage FSM states and default width.
package alu_pkg;
  localparam int ALU_XLEN_DEFAULT = 32;
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_MUL = 4'b1000
  } alu_ctrl_e;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DONE     = 2'd2
  } alu_state_e;
endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-add multiplier, XLEN iterations, low XLEN bits of product.
// done/product_lo are combinational on the last iteration so the caller can register them on that edge.
module seq_multiplier #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product_lo
);
  localparam int CW = $clog2(XLEN);
  logic [XLEN-1:0] mcand_q, mplier_q, acc_q, acc_d;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  assign acc_d      = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign busy       = busy_q;
  assign done       = busy_q && (cnt_q == '0);
  assign product_lo = acc_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= CW'(XLEN - 1);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
      busy_q   <= (cnt_q != '0);
    end
  end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered execute stage with valid/ready handshakes on both sides.
// Define ALU_MUL_EN to add the 32-cycle iterative MUL op; otherwise MUL decodes as illegal.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = ALU_XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);
  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d, alu_res, mul_prod;
  logic            zero_q, zero_d, illegal_q, illegal_d, alu_ill;
  logic            accept, is_mul, mul_fin;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
  logic mul_busy, mul_done;
  assign is_mul  = (alu_control == ALU_MUL);
  assign mul_fin = mul_busy & mul_done;
  seq_multiplier #(.XLEN(XLEN)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept && is_mul),
    .a         (op_a),
    .b         (op_b),
    .busy      (mul_busy),
    .done      (mul_done),
    .product_lo(mul_prod)
  );
`else
  localparam bit MUL_EN = 1'b0;
  assign is_mul   = 1'b0;
  assign mul_fin  = 1'b0;
  assign mul_prod = '0;
`endif
  assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (alu_control)
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_ADD: alu_res = op_a + op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_SLT: alu_res = ($signed(op_a) < $signed(op_b)) ? XLEN'(1) : '0;
      ALU_MUL: alu_ill = !MUL_EN;
      default: alu_ill = 1'b1;
    endcase
  end
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    if (accept && is_mul) begin
      state_d = MUL_BUSY;
    end else if (accept) begin
      state_d   = DONE;
      result_d  = alu_res;
      zero_d    = (alu_res == '0);
      illegal_d = alu_ill;
    end else if (state_q == MUL_BUSY && mul_fin) begin
      state_d   = DONE;
      result_d  = mul_prod;
      zero_d    = (mul_prod == '0);
      illegal_d = 1'b0;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors with hand-computed expectations for alu_exec_unit.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, zero, illegal;
  logic [3:0]  alu_control;
  logic [31:0] op_a, op_b, result;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_control(alu_control),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .illegal    (illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    in_valid    = v;
    alu_control = c;
    op_a        = a;
    op_b        = b;
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    #3;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd0);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    drive(1'b1, 4'b0010, 32'd5, 32'd7);
    tick();
    in_valid = 1'b0;
    chk("add_valid", {31'b0, out_valid}, 32'd1);
    chk("add_result", result, 32'd12);
    chk("add_zero", {31'b0, zero}, 32'd0);
    chk("add_illegal", {31'b0, illegal}, 32'd0);
    tick();
    chk("add_valid_drop", {31'b0, out_valid}, 32'd0);

    drive(1'b1, 4'b0110, 32'h1234, 32'h1234);
    tick();
    chk("sub_result", result, 32'd0);
    chk("sub_zero", {31'b0, zero}, 32'd1);
    chk("b2b_in_ready", {31'b0, in_ready}, 32'd1);
    drive(1'b1, 4'b0111, 32'hFFFF_FFFF, 32'd1);
    tick();
    chk("slt_result", result, 32'd1);
    chk("slt_zero", {31'b0, zero}, 32'd0);
    chk("slt_valid", {31'b0, out_valid}, 32'd1);
    drive(1'b1, 4'b0111, 32'd1, 32'hFFFF_FFFF);
    tick();
    chk("slt_rev_result", result, 32'd0);
    drive(1'b1, 4'b0011, 32'h0000_FF00, 32'h0000_0FF0);
    tick();
    chk("xor_result", result, 32'h0000_F0F0);
    drive(1'b1, 4'b0010, 32'hFFFF_FFFF, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("add_wrap_result", result, 32'd0);
    chk("add_wrap_zero", {31'b0, zero}, 32'd1);
    tick();

    out_ready = 1'b0;
    drive(1'b1, 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
    tick();
    drive(1'b1, 4'b0001, 32'h1, 32'h2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_result", result, 32'hF000_F000);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_or_result", result, 32'd3);
    chk("bp_or_valid", {31'b0, out_valid}, 32'd1);
    tick();
    chk("bp_or_drop", {31'b0, out_valid}, 32'd0);

    drive(1'b1, 4'b1111, 32'h55, 32'hAA);
    tick();
    in_valid = 1'b0;
    chk("ill_valid", {31'b0, out_valid}, 32'd1);
    chk("ill_result", result, 32'd0);
    chk("ill_zero", {31'b0, zero}, 32'd1);
    chk("ill_illegal", {31'b0, illegal}, 32'd1);
    tick();

`ifdef ALU_MUL_EN
    drive(1'b1, 4'b1000, 32'h0001_0000, 32'h0001_0003);
    tick();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    chk("mul_busy_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 1; i < 32; i++) begin
      tick();
      chk("mul_wait_valid", {31'b0, out_valid}, 32'd0);
      chk("mul_wait_ready", {31'b0, in_ready}, 32'd0);
    end
    tick();
    chk("mul_valid", {31'b0, out_valid}, 32'd1);
    chk("mul_result", result, 32'h0003_0000);
    chk("mul_illegal", {31'b0, illegal}, 32'd0);
    chk("mul_zero", {31'b0, zero}, 32'd0);
    tick();
    drive(1'b1, 4'b1000, 32'd3, 32'd9);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("rstmul_busy", {31'b0, in_ready}, 32'd0);
`else
    drive(1'b1, 4'b1000, 32'h0001_0000, 32'h0001_0003);
    tick();
    in_valid = 1'b0;
    chk("mul_off_valid", {31'b0, out_valid}, 32'd1);
    chk("mul_off_result", result, 32'd0);
    chk("mul_off_zero", {31'b0, zero}, 32'd1);
    chk("mul_off_illegal", {31'b0, illegal}, 32'd1);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 4'b0010, 32'd20, 32'd22);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("rst_pre_result", result, 32'd42);
`endif
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", {31'b0, out_valid}, 32'd0);
    chk("rstmid_result", result, 32'd0);
    chk("rstmid_illegal", {31'b0, illegal}, 32'd0);
    chk("rstmid_zero", {31'b0, zero}, 32'd0);
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstrel_ready", {31'b0, in_ready}, 32'd1);
    drive(1'b1, 4'b0010, 32'd1, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("post_rst_valid", {31'b0, out_valid}, 32'd1);
    chk("post_rst_result", result, 32'd2);
    tick();
    chk("post_rst_drop", {31'b0, out_valid}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Registered execute stage that consumes the 4-bit ALU control code produced by the ALU control unit together with two operands, and returns a result plus a zero flag for branch resolution. Combinational ops complete in one cycle. An optional iterative shift-add multiplier adds a 32-cycle MUL op. Valid/ready handshakes on both sides let the execute stage stall the fetch/decode path while a multiply is in flight.

## Interface
- XLEN, 32: operand/result width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand bundle valid
- in_ready  out  1  stage can accept a bundle this cycle
- alu_control  in  4  op code from ALU control unit
- op_a  in  XLEN  operand A (rs1)
- op_b  in  XLEN  operand B (rs2 or immediate)
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  consumer accepts result this cycle
- result  out  XLEN  registered result
- zero  out  1  registered, 1 when result == 0
- illegal  out  1  registered, 1 when alu_control was not a supported code

## Operation
- Codes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLT (signed, result 1 or 0), 1000 MUL (low XLEN bits of product).
- Any other code, or MUL with the feature compiled out: result=0, zero=1, illegal=1, completes in one cycle.
- ADD/SUB wrap modulo 2^XLEN; no overflow flag.
- FSM states:
  - IDLE: in_ready=1.
    - Accept of a single-cycle op -> DONE.
    - Accept of MUL -> MUL_BUSY.
  - MUL_BUSY: in_ready=0.
    - One iteration per cycle, iteration counter counting XLEN-1 down to 0.
    - At counter 0 -> DONE.
  - DONE: out_valid=1; result, zero and illegal are held stable.
    - out_ready=1 with in_valid=0 -> IDLE.
    - out_ready=1 with in_valid=1 -> back-to-back accept; next state depends on the new op.
    - out_ready=0 -> stay in DONE.
- in_ready = (state==IDLE) or (state==DONE and out_ready).
- A transfer happens on an edge where in_valid and in_ready are both 1. Inputs are sampled only on that edge and may change freely afterwards.
- zero and illegal are computed from the final result and registered together with it.

## Timing
- Reset values, applied asynchronously: state IDLE, out_valid 0, result 0, zero 0, illegal 0, iteration counter 0, multiplier registers 0.
- Single-cycle op accepted on edge t: out_valid=1 after edge t, i.e. latency 1.
- MUL accepted on edge t: operands are loaded on edge t. Iterations run on edges t+1 … t+XLEN. out_valid=1 after edge t+XLEN, i.e. latency 32.
- Back-to-back single-cycle ops with out_ready held at 1 give one result per cycle.
- out_ready is ignored in IDLE and MUL_BUSY.
- in_valid is ignored while in_ready=0.
- Reset asserted mid-multiply: the operation is abandoned, no result is produced, and the FSM is in IDLE once reset is released.

## Configuration
- ALU_MUL_EN defined: MUL code 1000 is supported, the MUL_BUSY state and multiplier sub-module are instantiated, and illegal stays 0 for MUL.
- ALU_MUL_EN undefined: no multiplier logic. Code 1000 behaves as illegal (result 0, zero 1, illegal 1, latency 1), and the FSM never enters MUL_BUSY.

## Structure
- Shared package alu_pkg holds:
  - alu_ctrl_e: 4-bit enum of the codes above. The ALU control unit uses the same package.
  - alu_state_e: IDLE, MUL_BUSY, DONE.
  - ALU_XLEN_DEFAULT = 32.
- One sub-module, seq_multiplier (XLEN parameter):
  - Inputs: start, a, b. Outputs: busy, done, product_lo.
  - Radix-2 shift-add: each cycle, if multiplier bit 0 is 1, add the multiplicand into the accumulator; then shift multiplicand left and multiplier right.
  - Instantiated only under ALU_MUL_EN.
- Combinational op mux and FSM live in alu_exec_unit.

## Test plan
- Reset then ADD: alu_control=0010, op_a=5, op_b=7, out_ready=1 -> result=12, zero=0, illegal=0, out_valid for exactly one cycle, 1 cycle after accept.
- SUB giving zero: 0110, op_a=op_b=0x1234 -> result=0, zero=1. SLT: 0111, op_a=0xFFFFFFFF, op_b=1 -> result=1.
- Backpressure: AND of 0xF0F0F0F0 and 0xFF00FF00 with out_ready=0 for 5 cycles:
  - result 0xF000F000 is held stable and in_ready=0 for all 5 cycles.
  - When out_ready rises, the next queued OR (0x1 | 0x2) is accepted on the same edge and yields 3 one cycle later.
- MUL (ALU_MUL_EN): code 1000, op_a=0x10000, op_b=0x10003 -> result 0x30000 (low 32 bits), out_valid exactly 32 cycles after accept, in_ready=0 throughout.
- MUL without ALU_MUL_EN, and code 1111 in any build -> result=0, zero=1, illegal=1, latency 1.
- rst_n pulsed low 10 cycles into a MUL -> out_valid, result and illegal return to 0 immediately. After release, in_ready=1, and a following ADD 1+1 returns 2 with latency 1.
